// File: rtl/debounce_entradas.sv
// Three-channel switch/sensor debouncer: two-flop synchroniser, per-channel
// agreement counter, registered edge pulses and a startup-settled flag.
module debounce_entradas #(
  parameter int DEB_MAX = 50000,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic L_raw,
  input  logic B_raw,
  input  logic Pre_raw,
  output logic L,
  output logic B,
  output logic Pre,
  output logic L_rise,
  output logic L_fall,
  output logic B_rise,
  output logic B_fall,
  output logic Pre_rise,
  output logic Pre_fall,
  output logic Valid
);

  localparam int N_CH = 3;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEB_MAX - 1);
  // One extra bit so DEB_MAX+1 fits even when DEB_MAX == 2**CNT_W.
  localparam logic [CNT_W:0]   START_LAST = (CNT_W + 1)'(DEB_MAX + 1);

  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [N_CH-1:0]  stable;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W:0]   start_cnt;

  assign raw = {Pre_raw, B_raw, L_raw};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would collapse s1/s2 into one flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // NOTE: the counter array is only three words, so it is reset like any
  // other register; a reset taken on an accepting edge must also drop the pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= '0;
      rise   <= '0;
      fall   <= '0;
      for (int ch = 0; ch < N_CH; ch++) cnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        rise[ch] <= 1'b0;
        fall[ch] <= 1'b0;
        if (s2[ch] == stable[ch]) begin
          cnt[ch] <= '0;
        end else if (cnt[ch] == CNT_LAST) begin
          stable[ch] <= s2[ch];
          cnt[ch]    <= '0;
          rise[ch]   <= s2[ch];
          fall[ch]   <= ~s2[ch];
        end else begin
          cnt[ch] <= cnt[ch] + 1'b1;
        end
      end
    end
  end

  // Valid rises on the same edge a level held since release would be accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_cnt <= '0;
      Valid     <= 1'b0;
    end else begin
      if (start_cnt != START_LAST) start_cnt <= start_cnt + 1'b1;
      if (start_cnt == START_LAST) Valid <= 1'b1;
    end
  end

  assign L        = stable[0];
  assign B        = stable[1];
  assign Pre      = stable[2];
  assign L_rise   = rise[0];
  assign L_fall   = fall[0];
  assign B_rise   = rise[1];
  assign B_fall   = fall[1];
  assign Pre_rise = rise[2];
  assign Pre_fall = fall[2];

endmodule

// File: tb/tb_debounce_entradas.sv
// Bench for debounce_entradas with DEB_MAX=4: expected pulses are queued when
// inputs change and matched against observed pulses edge by edge.
module tb_debounce_entradas;

  localparam int DEB_MAX = 4;
  localparam int CNT_W   = 3;
  localparam int LAT     = DEB_MAX + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic L_raw = 1'b0, B_raw = 1'b0, Pre_raw = 1'b0;
  logic L, B, Pre, L_rise, L_fall, B_rise, B_fall, Pre_rise, Pre_fall, Valid;

  debounce_entradas #(.DEB_MAX(DEB_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .L_raw(L_raw), .B_raw(B_raw), .Pre_raw(Pre_raw),
    .L(L), .B(B), .Pre(Pre),
    .L_rise(L_rise), .L_fall(L_fall), .B_rise(B_rise), .B_fall(B_fall),
    .Pre_rise(Pre_rise), .Pre_fall(Pre_fall), .Valid(Valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    bit rising;
    int at_edge;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  edge_n   = 0;

  task automatic expect_pulse(input int ch, input bit rising);
    ev_t e;
    e.ch = ch;
    e.rising = rising;
    e.at_edge = edge_n + LAT;
    exp_q.push_back(e);
  endtask

  // Scoreboard comparator: runs after every edge.
  task automatic score_pulses();
    logic [2:0] r;
    logic [2:0] f;
    ev_t e;
    r = {Pre_rise, B_rise, L_rise};
    f = {Pre_fall, B_fall, L_fall};
    while (exp_q.size() > 0 && exp_q[0].at_edge < edge_n) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL pulse_missed ch=%0d rising=%0b: no pulse observed, required at edge %0d",
               e.ch, e.rising, e.at_edge);
    end
    for (int ch = 0; ch < 3; ch++) begin
      for (int d = 1; d >= 0; d--) begin
        if ((d == 1) ? r[ch] : f[ch]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pulse_unexpected ch=%0d rising=%0d at edge %0d, required none",
                     ch, d, edge_n);
          end else begin
            e = exp_q.pop_front();
            if (e.ch !== ch || int'(e.rising) !== d || e.at_edge !== edge_n) begin
              n_fail++;
              $display("FAIL pulse_match got ch=%0d rising=%0d edge=%0d, required ch=%0d rising=%0b edge=%0d",
                       ch, d, edge_n, e.ch, e.rising, e.at_edge);
            end
          end
        end
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_n++;
      #1;
      score_pulses();
    end
  endtask

  task automatic drain(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected pulses outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    L_raw = 1'b1;
    B_raw = 1'b0;
    Pre_raw = 1'b0;
    step(3);
    n_checks++;
    if ({L, B, Pre, L_rise, L_fall, B_rise, B_fall, Pre_rise, Pre_fall, Valid} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b, required 0000000000",
               {L, B, Pre, L_rise, L_fall, B_rise, B_fall, Pre_rise, Pre_fall, Valid});
    end
    drain("reset");
  endtask

  // L_raw already high when reset releases: accepted as a rise on edge 6.
  task automatic test_startup();
    edge_n = 0;
    rst_n = 1'b1;
    expect_pulse(0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_checks++;
      if (Valid !== (k >= LAT) || L !== (k >= LAT) || B !== 1'b0 || Pre !== 1'b0) begin
        n_fail++;
        $display("FAIL startup_edge%0d got Valid=%b L=%b B=%b Pre=%b, required Valid=%b L=%b B=0 Pre=0",
                 k, Valid, L, B, Pre, k >= LAT, k >= LAT);
      end
    end
    drain("startup");
  endtask

  task automatic test_clean_fall();
    Pre_raw = 1'b1;
    expect_pulse(2, 1'b1);
    step(8);
    Pre_raw = 1'b0;
    expect_pulse(2, 1'b0);
    step(LAT - 1);
    n_checks++;
    if (Pre !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_early got Pre=%b, required 1", Pre);
    end
    step(1);
    n_checks++;
    if (Pre !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_accept got Pre=%b, required 0", Pre);
    end
    step(3);
    drain("clean_fall");
  endtask

  // Three-cycle pulse reaches cnt=DEB_MAX-1 then drops just before acceptance.
  task automatic test_glitch();
    B_raw = 1'b1;
    step(3);
    B_raw = 1'b0;
    step(10);
    n_checks++;
    if (B !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_level got B=%b, required 0", B);
    end
    B_raw = 1'b1;
    expect_pulse(1, 1'b1);
    step(8);
    n_checks++;
    if (B !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_retry got B=%b, required 1", B);
    end
    B_raw = 1'b0;
    expect_pulse(1, 1'b0);
    step(8);
    drain("glitch");
  endtask

  task automatic test_chatter();
    for (int i = 0; i < 50; i++) begin
      L_raw = ~L_raw;
      step(1);
      n_checks++;
      if (L !== 1'b1) begin
        n_fail++;
        $display("FAIL chatter_cycle%0d got L=%b, required 1", i, L);
      end
    end
    step(6);
    n_checks++;
    if (L !== 1'b1 || L_raw !== 1'b1) begin
      n_fail++;
      $display("FAIL chatter_end got L=%b L_raw=%b, required 1 1", L, L_raw);
    end
    drain("chatter");
  endtask

  task automatic test_simultaneous();
    L_raw = 1'b0;
    expect_pulse(0, 1'b0);
    step(8);
    L_raw = 1'b1;
    B_raw = 1'b1;
    Pre_raw = 1'b1;
    expect_pulse(0, 1'b1);
    expect_pulse(1, 1'b1);
    expect_pulse(2, 1'b1);
    step(LAT - 1);
    n_checks++;
    if ({L, B, Pre} !== 3'b000) begin
      n_fail++;
      $display("FAIL simul_early got LBP=%b, required 000", {L, B, Pre});
    end
    step(1);
    n_checks++;
    if ({L, B, Pre} !== 3'b111) begin
      n_fail++;
      $display("FAIL simul_accept got LBP=%b, required 111", {L, B, Pre});
    end
    step(2);
    drain("simultaneous");
  endtask

  // Reset lands on the edge that would accept L's fall: no pulse, all cleared.
  task automatic test_reset_mid_count();
    L_raw = 1'b0;
    step(LAT - 1);
    rst_n = 1'b0;
    step(1);
    n_checks++;
    if ({L, B, Pre, L_rise, L_fall, B_rise, B_fall, Pre_rise, Pre_fall, Valid} !== 10'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %b, required 0000000000",
               {L, B, Pre, L_rise, L_fall, B_rise, B_fall, Pre_rise, Pre_fall, Valid});
    end
    drain("midreset_pre");
    edge_n = 0;
    rst_n = 1'b1;
    expect_pulse(1, 1'b1);
    expect_pulse(2, 1'b1);
    step(LAT - 1);
    n_checks++;
    if ({L, B, Pre, Valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_restart got LBP_V=%b, required 0000", {L, B, Pre, Valid});
    end
    step(1);
    n_checks++;
    if ({L, B, Pre, Valid} !== 4'b0111) begin
      n_fail++;
      $display("FAIL midreset_accept got LBP_V=%b, required 0111", {L, B, Pre, Valid});
    end
    step(4);
    drain("midreset");
  endtask

  initial begin
    test_reset();
    test_startup();
    test_clean_fall();
    test_glitch();
    test_chatter();
    test_simultaneous();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
